// File: rtl/twilight_fade_ctrl.sv
// ============================================================================
// Module   : twilight_fade_ctrl
// Brief    : Frame-synchronous night/dawn/day/dusk fade sequencer that drives
//            the 8-bit fade_level consumed by the twilight background blender.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module twilight_fade_ctrl #(
    parameter int STEP_FRAMES       = 2,
    parameter int STEP_SIZE         = 1,
    parameter int HOLD_NIGHT_FRAMES = 120,
    parameter int HOLD_DAY_FRAMES   = 120
) (
    input  logic       clk_pix,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       enable,
    input  logic       skip,
    output logic [7:0] fade_level,
    output logic [1:0] phase,
    output logic       cycle_done
);

    localparam logic [1:0] c_NIGHT_HOLD = 2'd0;
    localparam logic [1:0] c_DAWN       = 2'd1;
    localparam logic [1:0] c_DAY_HOLD   = 2'd2;
    localparam logic [1:0] c_DUSK       = 2'd3;

    localparam int c_HOLD_MAX = (HOLD_NIGHT_FRAMES > HOLD_DAY_FRAMES) ? HOLD_NIGHT_FRAMES
                                                                      : HOLD_DAY_FRAMES;
    localparam int c_HOLD_W   = (c_HOLD_MAX > 1) ? $clog2(c_HOLD_MAX) : 1;
    localparam int c_DIV_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    localparam logic [c_HOLD_W-1:0] c_NIGHT_LAST = c_HOLD_W'(HOLD_NIGHT_FRAMES - 1);
    localparam logic [c_HOLD_W-1:0] c_DAY_LAST   = c_HOLD_W'(HOLD_DAY_FRAMES - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST   = c_DIV_W'(STEP_FRAMES - 1);
    localparam logic [7:0]          c_STEP       = 8'(STEP_SIZE);

    logic [7:0]          r_fade;
    logic [1:0]          r_phase;
    logic                r_cycle_done;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_DIV_W-1:0]  r_div_cnt;

    logic       w_tick;
    logic       w_skip;
    logic [8:0] w_sum;
    logic [7:0] w_fade_up;
    logic [7:0] w_fade_dn;

    assign w_skip = skip & enable;
    assign w_tick = frame_start & enable & ~skip;

    // Ramp arithmetic saturates so the endpoints are always exactly 0 and 255.
    assign w_sum     = {1'b0, r_fade} + {1'b0, c_STEP};
    assign w_fade_up = w_sum[8] ? 8'hFF : w_sum[7:0];
    assign w_fade_dn = (r_fade > c_STEP) ? (r_fade - c_STEP) : 8'h00;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_fade       <= 8'h00;
            r_phase      <= c_NIGHT_HOLD;
            r_hold_cnt   <= '0;
            r_div_cnt    <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            if (w_skip) begin
                r_hold_cnt <= '0;
                r_div_cnt  <= '0;
                case (r_phase)
                    c_NIGHT_HOLD: r_phase <= c_DAWN;
                    c_DAWN: begin
                        r_fade  <= 8'hFF;
                        r_phase <= c_DAY_HOLD;
                    end
                    c_DAY_HOLD: r_phase <= c_DUSK;
                    default: begin
                        r_fade       <= 8'h00;
                        r_phase      <= c_NIGHT_HOLD;
                        r_cycle_done <= 1'b1;
                    end
                endcase
            end else if (w_tick) begin
                case (r_phase)
                    c_NIGHT_HOLD: begin
                        if (r_hold_cnt == c_NIGHT_LAST) begin
                            r_hold_cnt <= '0;
                            r_div_cnt  <= '0;
                            r_phase    <= c_DAWN;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    c_DAWN: begin
                        if (r_div_cnt == c_DIV_LAST) begin
                            r_div_cnt <= '0;
                            r_fade    <= w_fade_up;
                            if (w_fade_up == 8'hFF) begin
                                r_phase    <= c_DAY_HOLD;
                                r_hold_cnt <= '0;
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                        end
                    end
                    c_DAY_HOLD: begin
                        if (r_hold_cnt == c_DAY_LAST) begin
                            r_hold_cnt <= '0;
                            r_div_cnt  <= '0;
                            r_phase    <= c_DUSK;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (r_div_cnt == c_DIV_LAST) begin
                            r_div_cnt <= '0;
                            r_fade    <= w_fade_dn;
                            if (w_fade_dn == 8'h00) begin
                                r_phase      <= c_NIGHT_HOLD;
                                r_hold_cnt   <= '0;
                                r_cycle_done <= 1'b1;
                            end
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign fade_level = r_fade;
    assign phase      = r_phase;
    assign cycle_done = r_cycle_done;

endmodule

`default_nettype wire
